// File: rtl/lm32_ram.sv
`default_nettype none
// ============================================================================
// Module      : lm32_ram
// Description : Simple dual-port RAM with a registered read address and a
//               combinational read-out, so a same-edge write is seen first.
// Revision    : 1.0 - initial release
// ============================================================================
module lm32_ram #(
    parameter int data_width    = 1,
    parameter int address_width = 1
) (
    input  logic                     read_clk,
    input  logic                     write_clk,
    input  logic                     reset,
    input  logic [address_width-1:0] read_address,
    input  logic                     enable_read,
    input  logic [address_width-1:0] write_address,
    input  logic                     enable_write,
    input  logic                     write_enable,
    input  logic [data_width-1:0]    write_data,
    output logic [data_width-1:0]    read_data
);

    localparam int c_DEPTH = 1 << address_width;

    logic [data_width-1:0]    r_mem [0:c_DEPTH-1];
    logic [address_width-1:0] r_ra;
    logic                     w_wr_en;

    // Writes are gated off during reset; the array itself is never cleared.
    assign w_wr_en = enable_write & write_enable & ~reset;

    always_ff @(posedge write_clk) begin
        if (w_wr_en) begin
            r_mem[write_address] <= write_data;
        end
    end

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            r_ra <= '0;
        end else if (enable_read) begin
            r_ra <= read_address;
        end
    end

    // Reading through the registered address gives write-first behaviour.
    assign read_data = r_mem[r_ra];

endmodule
`default_nettype wire

// File: tb/tb_lm32_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_lm32_ram
// Description : Self-checking bench for lm32_ram against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm32_ram;

    localparam int DW    = 31;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] read_address;
    logic          enable_read;
    logic [AW-1:0] write_address;
    logic          enable_write;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    lm32_ram #(.data_width(DW), .address_width(AW)) dut (
        .read_clk      (clk),
        .write_clk     (clk),
        .reset         (reset),
        .read_address  (read_address),
        .enable_read   (enable_read),
        .write_address (write_address),
        .enable_write  (enable_write),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .read_data     (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array, written flags and the current read pointer.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_valid [DEPTH];
    int            m_ra;

    int n_vec;
    int n_err;

    task automatic check_value(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: read_data=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit er, input int ra, input bit ew, input bit we,
                         input int wa, input logic [DW-1:0] wd);
        enable_read   = er;
        read_address  = AW'(ra);
        enable_write  = ew;
        write_enable  = we;
        write_address = AW'(wa);
        write_data    = wd;
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare the read port shortly after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!reset && enable_write && write_enable) begin
            m_mem[int'(write_address)]   = write_data;
            m_valid[int'(write_address)] = 1'b1;
        end
        if (reset)            m_ra = 0;
        else if (enable_read) m_ra = int'(read_address);
        #1;
        if (m_valid[m_ra]) check_value(tag, read_data, m_mem[m_ra]);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_ra  = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;

        // Writes during reset must be dropped.
        reset = 1'b1;
        drive(1, 0, 1, 1, 0, 31'h11);
        tick("rst_wr");
        tick("rst_wr");
        reset = 1'b0;

        drive(1, 0, 1, 1, 0, 31'h55);
        tick("init0");
        check_value("reset_ra0", read_data, 31'h55);

        // Top address.
        drive(0, 0, 1, 1, 'h3FF, 31'h7FFFFFFF);
        tick("wr3ff");
        drive(1, 'h3FF, 0, 0, 0, 0);
        tick("rd3ff");
        check_value("top_addr", read_data, 31'h7FFFFFFF);

        // Held read address ignores a new address until enable_read.
        drive(1, 0, 0, 0, 0, 0);
        tick("ra0");
        drive(0, 5, 1, 1, 5, 31'h12345678);
        tick("hold");
        check_value("hold_ra", read_data, 31'h55);
        drive(1, 5, 0, 0, 0, 0);
        tick("rd5");
        check_value("rd5", read_data, 31'h12345678);

        // Same-edge read and write: write-first.
        drive(1, 7, 1, 1, 7, 31'h0000ABCD);
        tick("rdw7");
        check_value("rdw_same", read_data, 31'h0000ABCD);

        // Write to the held address appears without a new capture.
        drive(0, 0, 1, 1, 7, 31'h0000BEEF);
        tick("held_wr");
        check_value("held_wr", read_data, 31'h0000BEEF);

        // enable_write=0 blocks the strobe.
        drive(0, 0, 1, 1, 3, 31'h2);
        tick("wr3");
        drive(0, 0, 0, 1, 3, 31'h1);
        tick("gated");
        drive(1, 3, 0, 0, 0, 0);
        tick("rd3");
        check_value("ew_gate", read_data, 31'h2);

        // Asynchronous reset mid-cycle with ra=9.
        drive(1, 9, 1, 1, 9, 31'h1234);
        tick("wr9");
        check_value("rd9", read_data, 31'h1234);
        drive(0, 0, 1, 1, 9, 31'h0);
        #2;
        reset = 1'b1;
        m_ra  = 0;
        #1;
        check_value("async_rst", read_data, 31'h55);
        tick("in_rst");
        reset = 1'b0;
        drive(1, 9, 0, 0, 0, 0);
        tick("post_rst");
        check_value("mem9_kept", read_data, 31'h1234);

        // Fill every word with random data.
        for (int a = 0; a < DEPTH; a++) begin
            drive($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), 1, 1, a,
                  DW'($urandom()));
            tick("fill");
        end

        // Strobed zero sweep from top to bottom, strobe toggling.
        for (int a = DEPTH - 1; a >= 0; a--) begin
            drive(0, 0, 1, a[0], a, '0);
            tick("sweep");
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, a, 0, 0, 0, 0);
            tick("sweep_rd");
            check_value("sweep_chk", read_data, (a % 2 == 1) ? '0 : m_mem[a]);
        end

        // Random traffic concentrated on a few addresses for collisions.
        for (int i = 0; i < 2000; i++) begin
            int ra;
            int wa;
            ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                             : $urandom_range(0, 7);
            wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 7);
            drive($urandom_range(0, 1), ra, $urandom_range(0, 1),
                  $urandom_range(0, 1), wa, DW'($urandom()));
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lm32_ram.md
LM32_RAM -- requirements
Module: lm32_ram

Interface
REQ-001 Parameter data_width, default 1: word width in bits; legal range 1 or greater.
REQ-002 Parameter address_width, default 1: address width in bits; depth is 2^address_width words.
REQ-003 read_clk, input, 1 bit: clock for the read side.
REQ-004 write_clk, input, 1 bit: clock for the write side.
REQ-005 reset, input, 1 bit: reset input.
REQ-006 read_address, input, address_width bits: word address to read.
REQ-007 enable_read, input, 1 bit: when high, the read address is captured on the clock edge.
REQ-008 write_address, input, address_width bits: word address to write.
REQ-009 enable_write, input, 1 bit: write-port enable (global gate).
REQ-010 write_enable, input, 1 bit: write strobe.
REQ-011 write_data, input, data_width bits: data to write.
REQ-012 read_data, output, data_width bits: contents of the word at the registered read address.
REQ-013 The block SHALL use one clock: read_clk and write_clk SHALL be driven by the same clock, and all logic is in that single domain.
REQ-014 The reset SHALL be asynchronous and active-high, on the port named reset.

Function
REQ-015 Storage SHALL be a 2^address_width x data_width array with a simple dual-port organisation: one write port and one read port.
REQ-016 Write: on a rising clock edge with enable_write=1 and write_enable=1, mem[write_address] SHALL be set to write_data.
REQ-017 No write SHALL occur if either enable_write=0 or write_enable=0.
REQ-018 Read address register ra: on a rising clock edge with enable_read=1, ra SHALL be set to read_address; with enable_read=0, ra SHALL hold its value.
REQ-019 read_data SHALL equal mem[ra] combinationally from ra and the array. Read latency is 1 clock from read_address to read_data.
REQ-020 With enable_read=0, read_data SHALL stay stable unless the word at ra is written.
REQ-021 Read-during-write, same address at the same edge: after that edge, read_data SHALL show the newly written data (write-first behaviour).
REQ-022 A write to the word at the held ra address SHALL appear on read_data in the cycle after the write edge.
REQ-023 Simultaneous read and write to different addresses SHALL be independent of each other.
REQ-024 Addresses SHALL decode fully with no aliasing; both index 0 and index 2^address_width-1 SHALL be valid.
REQ-025 The block SHALL contain no handshake, back-pressure, or error outputs.

Reset
REQ-026 While reset=1, ra SHALL be cleared to 0 asynchronously, so read_data shows mem[0].
REQ-027 Reset SHALL NOT modify array contents.
REQ-028 Writes SHALL be suppressed while reset=1.
REQ-029 Array contents at power-up are undefined (X in simulation); users SHALL initialise any word before reading it.
REQ-030 If reset is asserted in the middle of operation, ra SHALL return to 0 immediately; the next enabled edge after deassertion SHALL resume normal behaviour.

Verification (data_width=31, address_width=10)
REQ-031 Write 0x7FFFFFFF to address 0x3FF, then read 0x3FF with enable_read=1 -> read_data=0x7FFFFFFF one edge after the address is captured.
REQ-032 Write 0x12345678 to address 5, then present address 5 with enable_read=0 while ra=0 -> read_data still shows mem[0]; set enable_read=1 -> 0x12345678 on the next edge.
REQ-033 Same-edge write 0x0000ABCD to address 7 and read address 7 -> read_data=0x0000ABCD after that edge.
REQ-034 Sweep all addresses 0x3FF down to 0, writing 0 to each, with enable_write=1 and write_enable toggled -> only strobed addresses read back 0; the others keep their prior values.
REQ-035 Assert reset mid-stream with ra=9 and mem[0]=0x55 -> read_data=0x55 immediately, with no clock edge needed; mem[9] is unchanged and reads back correctly after reset.
REQ-036 enable_write=0 with write_enable=1, writing 0x1 to address 3 (previously 0x2) -> address 3 still reads 0x2.
